uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage that consumes the frames produced by the transmit path (1 start bit, `data_size` data bits LSB first, 1 stop bit, line idle high). It oversamples `RxD` using a one-`clk`-wide tick from a `baud_rate_gen` instance running at `OVERSAMPLE` × baud. For 9600 baud on a 50 MHz clock, that instance uses `BAUD_DIV` = 326. The block delivers each received byte with a single-cycle valid strobe, flags framing errors, and feeds on-board checking or loopback logic for the LFSR/ASCII transmit chain.

---
 rtl/uart_receiver.sv | 158 +++++++++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receive stage with framing-error detection
module uart_receiver #(
    parameter int data_size  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 RxD,
    output logic [data_size-1:0] data,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int IDX_BITS = (data_size > 1) ? $clog2(data_size) : 1;
    localparam logic [CNT_BITS-1:0] HALF_M1  = CNT_BITS'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_BITS-1:0] FULL_M1  = CNT_BITS'(OVERSAMPLE - 1);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(data_size - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    logic                   r_sync1;
    logic                   r_rx_s;
    logic [CNT_BITS-1:0]    r_cnt;
    logic [IDX_BITS-1:0]    r_idx;
    logic [data_size-1:0]   r_shift;
    logic [data_size-1:0]   r_data;
    logic                   r_valid;
    logic                   r_ferr;

    state_t                 w_state_nxt;
    logic [CNT_BITS-1:0]    w_cnt_nxt;
    logic [CNT_BITS-1:0]    w_cnt_inc;
    logic [IDX_BITS-1:0]    w_idx_nxt;
    logic [data_size-1:0]   w_shift_nxt;
    logic [data_size-1:0]   w_data_nxt;
    logic                   w_valid_nxt;
    logic                   w_ferr_nxt;

    assign w_cnt_inc     = r_cnt + CNT_BITS'(1);
    assign data          = r_data;
    assign data_valid    = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != S_IDLE);

    // Two-flop synchronizer; reset to the idle line level so reset never fakes a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= RxD;
            r_rx_s  <= r_sync1;
        end
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Next-state logic; pulses default low so they last exactly one clk
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        if (sample_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
                S_START: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == HALF_M1) begin
                        w_cnt_nxt = '0;
                        if (r_rx_s) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_DATA;
                            w_idx_nxt   = '0;
                        end
                    end
                end
                S_DATA: begin
                    w_cnt_nxt = w_cnt_inc;
                    // A full bit period of ticks after the previous sample point
                    if (r_cnt == FULL_M1) begin
                        w_cnt_nxt   = '0;
                        w_shift_nxt = {r_rx_s, r_shift[data_size-1:1]};
                        w_idx_nxt   = r_idx + IDX_BITS'(1);
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = S_STOP;
                            w_idx_nxt   = '0;
                        end
                    end
                end
                S_STOP: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == FULL_M1) begin
                        w_cnt_nxt = '0;
                        if (r_rx_s) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    // Hold off until the line recovers so a break cannot look like a start bit
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_tick;
    logic       RxD;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Events as {is_framing_error, data}
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] last_good;
    logic [7:0] prev_data;
    int         busy_ticks = 0;
    int         viol_both  = 0;
    int         viol_data  = 0;

    uart_receiver #(
        .data_size (8),
        .OVERSAMPLE(16),
        .CNT_BITS  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .RxD          (RxD),
        .data         (data),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One tick every four clocks
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    // Monitor: records output pulses and per-cycle invariants
    initial begin
        prev_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                prev_data = data;
            end else begin
                if (data_valid)    obs_q.push_back({1'b0, data});
                if (framing_error) obs_q.push_back({1'b1, data});
                if (data_valid && framing_error) viol_both++;
                if ((data !== prev_data) && !data_valid) viol_data++;
                prev_data = data;
                if (sample_tick && busy) busy_ticks++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (sample_tick !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
        send_bit(stop);
    endtask

    task automatic check_events(input string tag);
        int n;
        check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] seq[4];
        int         b0;

        rst       = 1'b1;
        RxD       = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, data_valid}, 32'h0);
        check("rst_ferr", {31'd0, framing_error}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        wait_ticks(4);

        // Single frame 0x35
        send_frame(8'h35, 1'b1);
        exp_q.push_back({1'b0, 8'h35});
        last_good = 8'h35;
        wait_ticks(4);
        check_events("single");
        check("single_busy", {31'd0, busy}, 32'h0);
        check("single_data", {24'd0, data}, {24'd0, last_good});

        // Back-to-back frames
        seq = '{8'h30, 8'h37, 8'hFF, 8'h00};
        for (int k = 0; k < 4; k++) begin
            send_frame(seq[k], 1'b1);
            exp_q.push_back({1'b0, seq[k]});
            last_good = seq[k];
        end
        wait_ticks(4);
        check_events("b2b");
        check("b2b_data", {24'd0, data}, {24'd0, last_good});

        // Random good frame so the following error test has a nonzero byte to preserve
        v = 8'($urandom_range(1, 255));
        if (v == 8'h41) v = 8'h42;
        send_frame(v, 1'b1);
        exp_q.push_back({1'b0, v});
        last_good = v;

        // Framing error followed by a 40-bit break
        send_frame(8'h41, 1'b0);
        exp_q.push_back({1'b1, last_good});
        wait_ticks(40 * 16);
        check("break_busy", {31'd0, busy}, 32'h1);
        RxD = 1'b1;
        wait_ticks(20);
        check_events("ferr");
        check("ferr_busy", {31'd0, busy}, 32'h0);
        check("ferr_data", {24'd0, data}, {24'd0, last_good});

        // Short glitch on the idle line
        b0 = busy_ticks;
        RxD = 1'b0;
        wait_ticks(5);
        RxD = 1'b1;
        wait_ticks(20);
        check("glitch_busy_ticks", busy_ticks - b0, 32'd7);
        check_events("glitch");
        check("glitch_busy", {31'd0, busy}, 32'h0);

        // Reset during data bit 4
        v = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        RxD = v[4];
        wait_ticks(8);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_data", {24'd0, data}, 32'h0);
        check("mid_rst_valid", {31'd0, data_valid}, 32'h0);
        check("mid_rst_ferr", {31'd0, framing_error}, 32'h0);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        RxD = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        wait_ticks(20);
        check_events("aborted");
        send_frame(8'h5A, 1'b1);
        exp_q.push_back({1'b0, 8'h5A});
        last_good = 8'h5A;
        wait_ticks(4);
        check_events("after_rst");
        check("after_rst_data", {24'd0, data}, 32'h5A);

        // Loopback-style stream of ASCII digits '0'..'7'
        for (int k = 0; k < 20; k++) begin
            v = 8'h30 + 8'($urandom_range(0, 7));
            send_frame(v, 1'b1);
            exp_q.push_back({1'b0, v});
            last_good = v;
        end
        wait_ticks(4);
        check_events("loop");
        check("loop_data", {24'd0, data}, {24'd0, last_good});
        check("loop_busy", {31'd0, busy}, 32'h0);

        check("never_both_pulses", viol_both, 32'd0);
        check("data_changes_only_with_valid", viol_data, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
